// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multicycle MIPS-subset controller
//   state codes (4b), opcode/funct values and the datapath select encodings
package mc_ctrl_pkg;

    localparam logic [3:0] S_RST      = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_R_EXEC   = 4'd3;
    localparam logic [3:0] S_R_WB     = 4'd4;
    localparam logic [3:0] S_I_EXEC   = 4'd5;
    localparam logic [3:0] S_I_WB     = 4'd6;
    localparam logic [3:0] S_MEM_ADDR = 4'd7;
    localparam logic [3:0] S_MEM_RD   = 4'd8;
    localparam logic [3:0] S_MEM_WB   = 4'd9;
    localparam logic [3:0] S_MEM_WR   = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_JAL      = 4'd13;
    localparam logic [3:0] S_JR       = 4'd14;
    localparam logic [3:0] S_HALT     = 4'd15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] F_NOP = 6'b000000;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_OUT  = 2'b01;
    localparam logic [1:0] PCS_JMP  = 2'b10;
    localparam logic [1:0] PCS_REGA = 2'b11;

    localparam logic [1:0] SRCB_B  = 2'b00;
    localparam logic [1:0] SRCB_4  = 2'b01;
    localparam logic [1:0] SRCB_SE = 2'b10;
    localparam logic [1:0] SRCB_SH = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_31 = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: R-type funct to ALU operation decode (combinational)
//   funct  in  6  IR[5:0]
//   alu_op out 3  add/sub/slt; unknown functs fall back to add
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op
);

    always_comb alu_op = (funct == F_SUB) ? ALU_SUB : (funct == F_SLT) ? ALU_SLT : ALU_ADD;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-subset control FSM with memory handshake and timeout
//   in : clk, rst_n (async, active-low), opcode[5:0], funct[5:0], zero, mem_ready
//   out: mem_read, mem_write, iord, ir_write, pc_en, pc_src[1:0], alu_src_a, alu_src_b[1:0],
//        alu_op[2:0], reg_dst[1:0], mem_to_reg[1:0], reg_write, illegal, mem_timeout,
//        cycle_cnt/instr_cnt[CNT_W-1:0] (live only with PERF_CNT_EN defined, else tied to 0)
//   WAIT_LIMIT: mem_ready wait cycles allowed per access before HALT (0 = unlimited)
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    logic [3:0]    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [2:0]    r_op;
    logic          mem_st;

    mc_alu_dec u_alu_dec (.funct(funct), .alu_op(r_op));

    always_comb begin
        state_d     = state_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_en       = 1'b0;
        pc_src      = PCS_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_B;
        alu_op      = ALU_ADD;
        reg_dst     = RD_RT;
        mem_to_reg  = M2R_ALU;
        reg_write   = 1'b0;
        illegal     = 1'b0;
        mem_timeout = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut captures the branch target while the opcode is dispatched
                alu_src_b = SRCB_SH;
                state_d   = S_FETCH;
                case (opcode)
                    OP_R: case (funct)
                        F_ADD, F_SUB, F_SLT: state_d = S_R_EXEC;
                        F_JR: state_d = S_JR;
                        F_NOP: ;
                        default: illegal = 1'b1;
                    endcase
                    OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J: state_d = S_JUMP;
                    OP_JAL: state_d = S_JAL;
                    default: illegal = 1'b1;
                endcase
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = r_op;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_dst   = RD_RD;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SE;
                alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SE;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_to_reg = M2R_MDR;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PCS_OUT;
                pc_en     = zero ^ (opcode == OP_BNE);
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = PCS_JMP;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                pc_src     = PCS_JMP;
                pc_en      = 1'b1;
                reg_dst    = RD_31;
                mem_to_reg = M2R_PC;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_JR: begin
                pc_src  = PCS_REGA;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: mem_timeout = 1'b1;
            default: state_d = S_RST;
        endcase
        // memory states only leave on mem_ready, so clearing whenever not waiting
        // is the same as clearing on state entry
        mem_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        wait_d = '0;
        if (mem_st && !mem_ready && WAIT_LIMIT != 0) begin
            if (wait_q == WW'(WAIT_LIMIT - 1)) state_d = S_HALT;
            else wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;
    logic             retire;

    always_comb begin
        retire = (state_q == S_R_WB) || (state_q == S_I_WB) || (state_q == S_MEM_WB) ||
                 (state_q == S_MEM_WR && mem_ready) || (state_q == S_BRANCH) ||
                 (state_q == S_JUMP) || (state_q == S_JAL) || (state_q == S_JR) ||
                 (state_q == S_DECODE && opcode == OP_R && funct == F_NOP);
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        instr_cnt_d = instr_cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule
